// File: rtl/lpm_outpad_arbiter_pkg.sv
// Shared state encoding and parameter limits for the output-pad arbiter.
package lpm_outpad_arbiter_pkg;

    localparam int unsigned MAX_REQUESTERS = 8;
    localparam int unsigned MAX_TURNAROUND = 7;
    localparam int unsigned MAX_HOLD       = 255;

    localparam int unsigned PTR_W  = $clog2(MAX_REQUESTERS);
    localparam int unsigned TURN_W = $clog2(MAX_TURNAROUND + 1);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

endpackage

// File: rtl/lpm_outpad_arbiter_rr_select.sv
// Combinational round-robin selector: first requester at or after ptr wins.
module lpm_rr_select
    import lpm_outpad_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [PTR_W-1:0] idx_o
);

    logic        found;
    logic [31:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract is the modulo.
            cand = 32'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && req_i[j] && (cand == j)) begin
                    found       = 1'b1;
                    onehot_o[j] = 1'b1;
                    idx_o       = PTR_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/lpm_outpad_arbiter.sv
// Round-robin arbiter that hands a shared output pad to one requester at a time,
// with a bounded burst length and a dead turnaround gap between owners.
module lpm_outpad_arbiter
    import lpm_outpad_arbiter_pkg::*;
#(
    parameter     lpm_type       = "lpm_outpad_arbiter",
    parameter int lpm_width      = 1,
    parameter int lpm_requesters = 2,
    parameter int lpm_turnaround = 1,
    parameter int lpm_maxhold    = 0,
    parameter     lpm_hint       = "UNUSED"
) (
    input  logic                                clock,
    input  logic                                aclr_n,
    input  logic [lpm_requesters-1:0]           req,
    input  logic [lpm_requesters-1:0]           last,
    input  logic [lpm_requesters*lpm_width-1:0] data,
    output logic [lpm_requesters-1:0]           grant,
    output logic [lpm_width-1:0]                pad,
    output logic                                pad_oe,
    output logic                                busy
);

    state_e                    state_q;
    logic [PTR_W-1:0]          ptr_q;
    logic [PTR_W-1:0]          owner_q;
    logic [HOLD_W-1:0]         hold_q;
    logic [TURN_W-1:0]         turn_q;
    logic [lpm_requesters-1:0] grant_q;
    logic [lpm_width-1:0]      pad_q;
    logic                      pad_oe_q;

    logic [lpm_requesters-1:0] win_onehot;
    logic [PTR_W-1:0]          win_idx;
    logic                      own_req;
    logic                      own_last;
    logic [lpm_width-1:0]      own_data;
    logic                      hold_done;

    lpm_rr_select #(
        .N (lpm_requesters)
    ) u_rr_select (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (win_onehot),
        .idx_o    (win_idx)
    );

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int unsigned j = 0; j < lpm_requesters; j++) begin
            if (owner_q == PTR_W'(j)) begin
                own_req  = req[j];
                own_last = last[j];
                own_data = data[j*lpm_width +: lpm_width];
            end
        end
    end

    assign hold_done = (lpm_maxhold != 0) && (hold_q == HOLD_W'(lpm_maxhold));

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            hold_q   <= '0;
            turn_q   <= '0;
            grant_q  <= '0;
            pad_q    <= '0;
            pad_oe_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pad_q    <= '0;
                    pad_oe_q <= 1'b0;
                    if (|req) begin
                        grant_q <= win_onehot;
                        owner_q <= win_idx;
                        ptr_q   <= (win_idx == PTR_W'(lpm_requesters - 1)) ?
                                   '0 : win_idx + PTR_W'(1);
                        hold_q  <= HOLD_W'(1);
                        state_q <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // A dropped request ends the burst without moving data.
                    if (own_req) begin
                        pad_q    <= own_data;
                        pad_oe_q <= 1'b1;
                    end else begin
                        pad_q    <= '0;
                        pad_oe_q <= 1'b0;
                    end
                    if (!own_req || own_last || hold_done) begin
                        grant_q <= '0;
                        hold_q  <= '0;
                        if (lpm_turnaround > 0) begin
                            state_q <= ST_TURN;
                            turn_q  <= TURN_W'(lpm_turnaround);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if ((lpm_maxhold != 0) && (hold_q != HOLD_W'(MAX_HOLD))) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_TURN: begin
                    pad_q    <= '0;
                    pad_oe_q <= 1'b0;
                    turn_q   <= turn_q - TURN_W'(1);
                    if (turn_q <= TURN_W'(1)) begin
                        turn_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    grant_q  <= '0;
                    pad_q    <= '0;
                    pad_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign pad    = pad_q;
    assign pad_oe = pad_oe_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lpm_outpad_arbiter.sv
// Directed self-checking bench for lpm_outpad_arbiter in three configurations.
module tb_lpm_outpad_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]  a_req, a_last, a_grant;
    logic [15:0] a_data;
    logic [7:0]  a_pad;
    logic        a_oe, a_busy;

    logic [1:0]  b_req, b_last, b_grant;
    logic [15:0] b_data;
    logic [7:0]  b_pad;
    logic        b_oe, b_busy;

    logic [3:0]  c_req, c_last, c_grant;
    logic [15:0] c_data;
    logic [3:0]  c_pad;
    logic        c_oe, c_busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] b_eg  [0:8];
    logic       b_eoe [0:8];
    logic [7:0] b_ep  [0:8];
    logic [3:0] c_eg  [0:12];
    logic [3:0] c_ep  [0:12];

    always #5 clk = ~clk;

    lpm_outpad_arbiter #(
        .lpm_width      (8),
        .lpm_requesters (2),
        .lpm_turnaround (2),
        .lpm_maxhold    (0)
    ) u_a (
        .clock (clk), .aclr_n (rst_n), .req (a_req), .last (a_last), .data (a_data),
        .grant (a_grant), .pad (a_pad), .pad_oe (a_oe), .busy (a_busy)
    );

    lpm_outpad_arbiter #(
        .lpm_width      (8),
        .lpm_requesters (2),
        .lpm_turnaround (0),
        .lpm_maxhold    (3)
    ) u_b (
        .clock (clk), .aclr_n (rst_n), .req (b_req), .last (b_last), .data (b_data),
        .grant (b_grant), .pad (b_pad), .pad_oe (b_oe), .busy (b_busy)
    );

    lpm_outpad_arbiter #(
        .lpm_width      (4),
        .lpm_requesters (4),
        .lpm_turnaround (0),
        .lpm_maxhold    (1)
    ) u_c (
        .clock (clk), .aclr_n (rst_n), .req (c_req), .last (c_last), .data (c_data),
        .grant (c_grant), .pad (c_pad), .pad_oe (c_oe), .busy (c_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b_eg  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        b_eoe = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        b_ep  = '{8'h00, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hBB, 8'hBB, 8'h00};
        c_eg  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000,
                  4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
        c_ep  = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0, 4'h1,
                  4'h0, 4'h3, 4'h0};

        rst_n  = 1'b0;
        a_req  = '0; a_last = '0; a_data = '0;
        b_req  = '0; b_last = '0; b_data = '0;
        c_req  = '0; c_last = '0; c_data = '0;
        #2;
        chk("rst_a_grant", 64'(a_grant), 64'h0);
        chk("rst_a_pad",   64'(a_pad),   64'h0);
        chk("rst_a_oe",    64'(a_oe),    64'h0);
        chk("rst_a_busy",  64'(a_busy),  64'h0);
        chk("rst_b_grant", 64'(b_grant), 64'h0);
        chk("rst_c_oe",    64'(c_oe),    64'h0);

        // Reset release with both requesting: requester 0 first.
        a_req  = 2'b11;
        a_data = {8'h22, 8'h11};
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("a_first_grant", 64'(a_grant), 64'h1);
        chk("a_first_oe",    64'(a_oe),    64'h0);
        chk("a_first_busy",  64'(a_busy),  64'h1);
        tick;
        chk("a_data1_pad", 64'(a_pad), 64'h11);
        chk("a_data1_oe",  64'(a_oe),  64'h1);
        a_data[7:0] = 8'h33;
        tick;
        chk("a_data2_pad", 64'(a_pad), 64'h33);
        a_data[7:0] = 8'h44;
        tick;
        chk("a_data3_pad",   64'(a_pad),   64'h44);
        chk("a_data3_grant", 64'(a_grant), 64'h1);
        a_data[7:0] = 8'h55;
        a_last      = 2'b01;
        tick;
        chk("a_last_pad",   64'(a_pad),   64'h55);
        chk("a_last_oe",    64'(a_oe),    64'h1);
        chk("a_last_grant", 64'(a_grant), 64'h0);
        a_last = 2'b00;
        tick;
        chk("a_turn1_oe",   64'(a_oe),   64'h0);
        chk("a_turn1_pad",  64'(a_pad),  64'h0);
        chk("a_turn1_busy", 64'(a_busy), 64'h1);
        tick;
        chk("a_turn2_oe",    64'(a_oe),    64'h0);
        chk("a_turn2_grant", 64'(a_grant), 64'h0);
        chk("a_turn2_busy",  64'(a_busy),  64'h0);
        tick;
        chk("a_idle_oe",     64'(a_oe),    64'h0);
        chk("a_next_grant",  64'(a_grant), 64'h2);
        tick;
        chk("a_own1_pad", 64'(a_pad), 64'h22);
        chk("a_own1_oe",  64'(a_oe),  64'h1);

        // Owner 1 drops req on its second ownership cycle.
        a_req = 2'b00;
        tick;
        chk("a_drop_oe",    64'(a_oe),    64'h0);
        chk("a_drop_pad",   64'(a_pad),   64'h0);
        chk("a_drop_grant", 64'(a_grant), 64'h0);
        chk("a_drop_busy",  64'(a_busy),  64'h1);
        tick;
        chk("a_drop_turn_busy", 64'(a_busy), 64'h1);
        tick;
        chk("a_drop_idle_busy", 64'(a_busy), 64'h0);

        // Mid-burst asynchronous reset; ptr is 1 before reset, 0 after.
        a_req  = 2'b11;
        a_data = {8'h5A, 8'hA5};
        tick;
        chk("a_pre_rst_grant", 64'(a_grant), 64'h1);
        tick;
        chk("a_pre_rst_pad", 64'(a_pad), 64'hA5);
        chk("a_pre_rst_oe",  64'(a_oe),  64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_async_pad",   64'(a_pad),   64'h0);
        chk("a_async_oe",    64'(a_oe),    64'h0);
        chk("a_async_grant", 64'(a_grant), 64'h0);
        chk("a_async_busy",  64'(a_busy),  64'h0);
        #2;
        rst_n = 1'b1;
        tick;
        chk("a_post_rst_grant", 64'(a_grant), 64'h1);
        a_req = 2'b00;

        // Max-hold preemption with zero turnaround.
        b_req  = 2'b11;
        b_data = {8'hBB, 8'hAA};
        for (int i = 0; i < 9; i++) begin
            tick;
            chk($sformatf("b_grant[%0d]", i), 64'(b_grant), 64'(b_eg[i]));
            chk($sformatf("b_oe[%0d]", i),    64'(b_oe),    64'(b_eoe[i]));
            chk($sformatf("b_pad[%0d]", i),   64'(b_pad),   64'(b_ep[i]));
        end
        b_req = 2'b00;

        // Four requesters, single-cycle bursts: rotation and skip of idle requesters.
        c_req  = 4'hF;
        c_data = 16'h4321;
        for (int i = 0; i < 13; i++) begin
            if (i == 10) c_req = 4'b0101;
            tick;
            chk($sformatf("c_grant[%0d]", i), 64'(c_grant), 64'(c_eg[i]));
            chk($sformatf("c_pad[%0d]", i),   64'(c_pad),   64'(c_ep[i]));
        end
        c_req = 4'h0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
